if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port ds_allowin, input, 1 bit: the decode stage can accept an instruction this cycle.
REQ-004 SHALL have port br_bus, input, 33 bits: {br_taken[32], br_target[31:0]} from decode, valid for the cycle it is asserted.
REQ-005 SHALL have port fs_to_ds_valid, output, 1 bit: fs_to_ds_bus carries a valid instruction.
REQ-006 SHALL have port fs_to_ds_bus, output, 64 bits: {fs_pc[63:32], fs_inst[31:0]}.
REQ-007 SHALL have port inst_sram_en, output, 1 bit: fetch request enable.
REQ-008 SHALL have port inst_sram_we, output, 1 bit: tied to 0.
REQ-009 SHALL have port inst_sram_addr, output, 32 bits: fetch address.
REQ-010 SHALL have port inst_sram_wdata, output, 32 bits: tied to 0.
REQ-011 SHALL have port inst_sram_rdata, input, 32 bits: read data, valid one cycle after an enabled request.

Function
REQ-012 SHALL compute seq_pc = fs_pc + 4 (32-bit, wrap modulo 2^32) and nextpc = br_taken ? br_target : seq_pc.
REQ-013 SHALL drive to_fs_valid = 1 in every cycle with reset deasserted.
REQ-014 SHALL compute fs_ready_go = 1 and fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin) | br_taken.
REQ-015 SHALL drive inst_sram_en = to_fs_valid & fs_allowin and inst_sram_addr = nextpc, combinationally.
REQ-016 SHALL, on a clock edge with inst_sram_en = 1, load fs_pc <= nextpc and set fs_valid <= 1.
REQ-017 SHALL, when fs_valid = 1 and no new request is accepted, hold fs_pc and fs_valid.
REQ-018 SHALL drive fs_to_ds_valid = fs_valid & fs_ready_go & ~br_taken.
REQ-019 SHALL drive fs_inst = buf_valid ? inst_buf : inst_sram_rdata.
REQ-020 SHALL, in a cycle with fs_valid = 1, ds_allowin = 0, br_taken = 0 and buf_valid = 0, capture inst_sram_rdata into inst_buf and set buf_valid <= 1.
REQ-021 SHALL clear buf_valid on any edge where a new fetch request is accepted.
REQ-022 SHALL give br_taken priority over ds_allowin; in that cycle:
- the instruction currently in fetch is discarded (never presented to decode);
- buf_valid is cleared;
- the br_target request is issued in the same cycle.
REQ-023 SHALL handle br_taken asserted while fs_valid = 0 by issuing br_target with no instruction discarded.
REQ-024 SHALL have an instruction-to-decode latency of 1 cycle from the request edge when ds_allowin = 1.
REQ-025 SHALL deliver each fetched PC to decode exactly once, in program order, with no duplication across stall cycles.

Reset
REQ-026 SHALL, while reset = 1, asynchronously force fs_valid = 0, buf_valid = 0, inst_buf = 0 and fs_pc = 32'h1bff_fffc.
REQ-027 SHALL drive the following values during reset: fs_to_ds_valid = 0, inst_sram_en = 0, inst_sram_we = 0, inst_sram_wdata = 0.
REQ-028 SHALL, in the first cycle after reset deasserts, request address 32'h1c00_0000.
REQ-029 SHALL, when reset is asserted mid-stall or mid-branch, abandon the pending or buffered instruction with no output to decode.

Structure
REQ-030 SHALL take the following constants from the shared package cpu_defs_pkg: RESET_PC_M4 = 32'h1bff_fffc, BR_BUS_WD = 33, FS_TO_DS_BUS_WD = 64.
REQ-031 SHALL implement the stall buffer as the single sub-module if_inst_buf (capture, hold, clear).
REQ-032 SHALL contain no combinational path from inst_sram_rdata to inst_sram_addr.

Verification
REQ-033 SHALL pass a reset-release test: reset held 3 cycles then released; inst_sram_en = 1 with addr 0x1c000000; the next cycle fs_to_ds_valid = 1 and fs_pc = 0x1c000000.
REQ-034 SHALL pass a sequential-streaming test: ds_allowin = 1 with rdata = addr; the bus shows PCs 0x1c000000, 0x1c000004 and 0x1c000008 on consecutive cycles.
REQ-035 SHALL pass a stall test: ds_allowin = 0 for 3 cycles at pc 0x1c000004 while rdata changes to 0xdeadbeef; fs_inst stays at the original word, inst_sram_en = 0, and after release 0x1c000008 follows.
REQ-036 SHALL pass a taken-branch test: br_taken with target 0x1c000100 while fs_valid holds 0x1c000008; the same cycle shows fs_to_ds_valid = 0 and addr 0x1c000100, and the next delivered PC is 0x1c000100.
REQ-037 SHALL pass a branch-during-stall test: ds_allowin = 0 with buf_valid = 1, then br_taken with target 0x1c000200; the buffer clears, 0x1c000200 is fetched, and the stale instruction is never delivered.
REQ-038 SHALL pass a wrap test: fs_pc = 0xfffffffc with no branch; the next request address is 0x00000000.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU constants and bus layouts used by the fetch stage and its neighbours.
package cpu_defs_pkg;
  localparam logic [31:0] RESET_PC_M4     = 32'h1bff_fffc;
  localparam int          BR_BUS_WD       = 33;
  localparam int          FS_TO_DS_BUS_WD = 64;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fs_to_ds_t;
endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage boundary: decode handshake, branch redirect and instruction SRAM port.
interface if_stage_if;
  logic                                    ds_allowin;
  logic [cpu_defs_pkg::BR_BUS_WD-1:0]       br_bus;
  logic                                    fs_to_ds_valid;
  logic [cpu_defs_pkg::FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
  logic                                    inst_sram_en;
  logic                                    inst_sram_we;
  logic [31:0]                             inst_sram_addr;
  logic [31:0]                             inst_sram_wdata;
  logic [31:0]                             inst_sram_rdata;

  modport master (
    input  ds_allowin, br_bus, inst_sram_rdata,
    output fs_to_ds_valid, fs_to_ds_bus,
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );

  modport slave (
    output ds_allowin, br_bus, inst_sram_rdata,
    input  fs_to_ds_valid, fs_to_ds_bus,
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );
endinterface

// File: rtl/if_inst_buf.sv
// Stall buffer: holds the SRAM word while decode is blocked, since the SRAM
// read data is only valid for the single cycle after a request.
module if_inst_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic        clear,
  input  logic [31:0] din,
  output logic        buf_valid,
  output logic [31:0] inst_buf
);
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] inst_buf_q, inst_buf_d;

  always_comb begin
    buf_valid_d = buf_valid_q;
    inst_buf_d  = inst_buf_q;
    // A new request always wins; capture only the first stalled word.
    if (clear) begin
      buf_valid_d = 1'b0;
    end else if (capture && !buf_valid_q) begin
      buf_valid_d = 1'b1;
      inst_buf_d  = din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      inst_buf_q  <= 32'h0;
    end else begin
      buf_valid_q <= buf_valid_d;
      inst_buf_q  <= inst_buf_d;
    end
  end

  assign buf_valid = buf_valid_q;
  assign inst_buf  = inst_buf_q;
endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC generation, SRAM request, branch redirect and
// single-entry stall buffering toward decode.
module if_stage
  import cpu_defs_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  if_stage_if.master  fs
);
  br_bus_t     br;
  fs_to_ds_t   fs_out;
  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic [31:0] seq_pc, nextpc;
  logic        to_fs_valid, fs_ready_go, fs_allowin, sram_en;
  logic        buf_capture, buf_valid;
  logic [31:0] inst_buf, fs_inst;

  assign fs_ready_go = 1'b1;

  always_comb begin
    br          = fs.br_bus;
    seq_pc      = fs_pc_q + 32'd4;
    nextpc      = br.taken ? br.target : seq_pc;
    to_fs_valid = ~reset;
    // A taken branch always redirects, even when decode is stalled.
    fs_allowin  = ~fs_valid_q | (fs_ready_go & fs.ds_allowin) | br.taken;
    sram_en     = to_fs_valid & fs_allowin;
    buf_capture = fs_valid_q & ~fs.ds_allowin & ~br.taken;
    fs_valid_d  = fs_valid_q;
    fs_pc_d     = fs_pc_q;
    if (sram_en) begin
      fs_valid_d = 1'b1;
      fs_pc_d    = nextpc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_valid_q <= 1'b0;
      fs_pc_q    <= RESET_PC_M4;
    end else begin
      fs_valid_q <= fs_valid_d;
      fs_pc_q    <= fs_pc_d;
    end
  end

  if_inst_buf u_inst_buf (
    .clk       (clk),
    .reset     (reset),
    .capture   (buf_capture),
    .clear     (sram_en),
    .din       (fs.inst_sram_rdata),
    .buf_valid (buf_valid),
    .inst_buf  (inst_buf)
  );

  assign fs_inst     = buf_valid ? inst_buf : fs.inst_sram_rdata;
  assign fs_out.pc   = fs_pc_q;
  assign fs_out.inst = fs_inst;

  assign fs.fs_to_ds_valid  = fs_valid_q & fs_ready_go & ~br.taken;
  assign fs.fs_to_ds_bus    = fs_out;
  assign fs.inst_sram_en    = sram_en;
  assign fs.inst_sram_we    = 1'b0;
  assign fs.inst_sram_addr  = nextpc;
  assign fs.inst_sram_wdata = 32'h0;
endmodule
